multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing controller for the multicycle RV32I core; replaces the single-cycle control_unit.
- One Moore FSM steps each instruction through fetch, decode, execute, memory and writeback over a shared ALU and unified memory.
- Drives datapath muxes, write enables and an instruction-retire strobe.
- Stalls on a memory ready handshake.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access active
- adr_src  out  1  memory address select: 0=pc, 1=alu_out
- ir_write  out  1  load instruction register, latch old_pc
- pc_write  out  1  load pc with the result bus
- mem_write  out  1  store strobe
- reg_write  out  1  register file write
- result_src  out  2  00=alu_out, 01=read data, 10=alu_result
- alu_src_a  out  2  00=pc, 01=old_pc, 10=rd1
- alu_src_b  out  2  00=rd2, 01=imm, 10=const 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  3  000 I, 001 S, 010 B, 011 J; decoded from op in every state
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  unsupported opcode trap (see Optional Feature)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
- All outputs are combinational from state, op, funct3, funct7_5, zero and mem_ready. No output registers.
- Reset: state <= FETCH immediately, including mid-instruction. Outputs then take FETCH values with mem_ready=0:
  - mem_req=1, alu_src_b=10.
  - All other outputs 0; imm_src follows op.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add.
  - On mem_ready=1: ir_write=1, pc_write=1, result_src=10, next state DECODE.
  - On mem_ready=0: hold in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into alu_out). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> see Optional Feature
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next state MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready=1, then MEMWB.
- MEMWRITE:
  - mem_req=1, adr_src=1, mem_write=1 held every cycle until mem_ready=1.
  - On mem_ready=1: instr_done=1, next state FETCH.
- MEMWB: result_src=01, reg_write=1, instr_done=1, next state FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALU decode, next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALU decode, next state ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, next state FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write=zero.
  - instr_done=1, next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, next state ALUWB.
- ALU decode (EXECR/EXECI) by funct3:
  - 000: sub if op[5]&funct7_5, else add
  - 010: slt
  - 110: or
  - 111: and
  - other: add
- Latency with mem_ready tied 1, counted from FETCH entry:
  - lw 5 cycles
  - sw, R, I, jal 4 cycles
  - beq 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- instr_done pulses exactly once per instruction.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported op in DECODE goes to HALT.
  - HALT: illegal=1, all enables 0, no memory request. Stays until rst.
- Undefined:
  - An unsupported op in DECODE returns to FETCH with instr_done=1 (treated as NOP).
  - HALT unreachable; illegal tied 0.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants
  - FSM state encoding (4 bits)
  - alu_control codes
  - imm_src, result_src, alu_src_a and alu_src_b codes
- One sub-module, alu_decoder: combinational {alu_op[1:0], funct3, funct7_5, op[5]} -> alu_control.
- FSM and output decode stay in multicycle_controller.

Test Plan:
- rst=1 asserted mid-MEMREAD (async, between edges) -> state FETCH immediately; mem_req=1, alu_src_b=10, all write enables 0.
- op=0000011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 only in cycle 5; instr_done pulses once.
- op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> mem_write held 4 cycles. instr_done only on the mem_ready=1 cycle; no reg_write.
- op=1100011, funct3=000: zero=1 -> pc_write=1 in the BEQ cycle; zero=0 -> pc_write=0. Both take 3 cycles.
- op=0110011, funct3=000, funct7_5=1 -> alu_control=001 in EXECR. Same fields with op=0010011 -> 000 in EXECI. funct3=010 -> 101.
- op=1111111: with MC_ILLEGAL_TRAP_EN, illegal=1 from cycle 3 until rst; without it, back to FETCH on cycle 3 with instr_done=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared opcodes, FSM encoding and datapath select codes for the
//            multicycle RV32I controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Opcodes without an immediate (R-type, unsupported) fall back to I format.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Purpose  : Maps the controller's ALU operation class and instruction fields
//            onto the ALU control code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) may subtract; addi ignores instr[30].
                    3'b000:  alu_control = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore sequencing FSM for the multicycle RV32I core. Define
//            MC_ILLEGAL_TRAP_EN to halt on unsupported opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import riscv_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    result_src = RES_ALURES;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is precomputed here into alu_out.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // pc takes the DECODE target while the ALU forms old_pc+4 for rd.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: state_d = RESET_STATE;
        endcase
    end

    assign imm_src = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op_5        (op[5]),
        .alu_control (alu_control)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed per-cycle scoreboard bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adr_src, ir_write, pc_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic       instr_done, illegal;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [19:0] exp;
        string       name;
    } item_t;
    item_t sb_q[$];

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [19:0] got = {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
                       result_src, alu_src_a, alu_src_b, alu_control, imm_src,
                       instr_done, illegal};

    // Field order: mreq adr irw pcw mw rw result_src src_a src_b alu_ctl imm done ill
    function automatic logic [19:0] ev(input logic mreq, input logic adr, input logic irw,
                                       input logic pcw, input logic mw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [2:0] imm, input logic done,
                                       input logic ill);
        return {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, ac, imm, done, ill};
    endfunction

    function automatic logic [19:0] e_fstall(input logic [2:0] imm);
        return ev(1,0,0,0,0,0, 2'b00,2'b00,2'b10, 3'b000, imm, 0,0);
    endfunction
    function automatic logic [19:0] e_fhit(input logic [2:0] imm);
        return ev(1,0,1,1,0,0, 2'b10,2'b00,2'b10, 3'b000, imm, 0,0);
    endfunction
    function automatic logic [19:0] e_dec(input logic [2:0] imm, input logic done);
        return ev(0,0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, imm, done,0);
    endfunction
    function automatic logic [19:0] e_madr(input logic [2:0] imm);
        return ev(0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, imm, 0,0);
    endfunction
    function automatic logic [19:0] e_mrd(input logic [2:0] imm);
        return ev(1,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, imm, 0,0);
    endfunction
    function automatic logic [19:0] e_mwb(input logic [2:0] imm);
        return ev(0,0,0,0,0,1, 2'b01,2'b00,2'b00, 3'b000, imm, 1,0);
    endfunction
    function automatic logic [19:0] e_mwr(input logic [2:0] imm, input logic done);
        return ev(1,1,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, imm, done,0);
    endfunction
    function automatic logic [19:0] e_exr(input logic [2:0] ac);
        return ev(0,0,0,0,0,0, 2'b00,2'b10,2'b00, ac, 3'b000, 0,0);
    endfunction
    function automatic logic [19:0] e_exi(input logic [2:0] ac);
        return ev(0,0,0,0,0,0, 2'b00,2'b10,2'b01, ac, 3'b000, 0,0);
    endfunction
    function automatic logic [19:0] e_awb(input logic [2:0] imm);
        return ev(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, imm, 1,0);
    endfunction
    function automatic logic [19:0] e_beq(input logic z);
        return ev(0,0,0,z,0,0, 2'b00,2'b10,2'b00, 3'b001, 3'b010, 1,0);
    endfunction

    // One call per cycle: entered at posedge+1, leaves at the next posedge+1.
    task automatic cyc(input string name, input logic [19:0] e, input logic mrdy,
                       input logic z);
        item_t it;
        mem_ready = mrdy;
        zero      = z;
        it.exp    = e;
        it.name   = name;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        op       = o;
        funct3   = f3;
        funct7_5 = f75;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            item_t it;
            it = sb_q.pop_front();
            tests++;
            if (got !== it.exp) begin
                fails++;
                $display("FAIL %s: got %05h expected %05h (t=%0t)", it.name, got, it.exp, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, lw with fetch stall
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("rst_fetch",  e_fstall(3'b000), 0, 0);
        cyc("lw_fetch",   e_fhit(3'b000),   1, 0);
        cyc("lw_decode",  e_dec(3'b000, 0), 1, 0);
        cyc("lw_memadr",  e_madr(3'b000),   1, 0);
        cyc("lw_memread", e_mrd(3'b000),    1, 0);
        cyc("lw_memwb",   e_mwb(3'b000),    1, 0);

        // sw with one fetch stall and three MEMWRITE stalls
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fstall",  e_fstall(3'b001), 0, 0);
        cyc("sw_fetch",   e_fhit(3'b001),   1, 0);
        cyc("sw_decode",  e_dec(3'b001, 0), 1, 0);
        cyc("sw_memadr",  e_madr(3'b001),   1, 0);
        for (int i = 0; i < 3; i++) cyc("sw_wstall", e_mwr(3'b001, 0), 0, 0);
        cyc("sw_wdone",   e_mwr(3'b001, 1), 1, 0);

        // beq taken then not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc("beq1_fetch", e_fhit(3'b010),   1, 1);
        cyc("beq1_dec",   e_dec(3'b010, 0), 1, 1);
        cyc("beq_taken",  e_beq(1'b1),      1, 1);
        cyc("beq0_fetch", e_fhit(3'b010),   1, 0);
        cyc("beq0_dec",   e_dec(3'b010, 0), 1, 0);
        cyc("beq_not",    e_beq(1'b0),      1, 0);

        // R-type sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc("sub_fetch",  e_fhit(3'b000),   1, 0);
        cyc("sub_dec",    e_dec(3'b000, 0), 1, 0);
        cyc("sub_execr",  e_exr(3'b001),    1, 0);
        cyc("sub_aluwb",  e_awb(3'b000),    1, 0);

        // I-type with same fields is addi
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc("addi_fetch", e_fhit(3'b000),   1, 0);
        cyc("addi_dec",   e_dec(3'b000, 0), 1, 0);
        cyc("addi_execi", e_exi(3'b000),    1, 0);
        cyc("addi_aluwb", e_awb(3'b000),    1, 0);

        // slt, or, and
        set_instr(7'b0110011, 3'b010, 1'b0);
        cyc("slt_fetch",  e_fhit(3'b000),   1, 0);
        cyc("slt_dec",    e_dec(3'b000, 0), 1, 0);
        cyc("slt_execr",  e_exr(3'b101),    1, 0);
        cyc("slt_aluwb",  e_awb(3'b000),    1, 0);
        set_instr(7'b0010011, 3'b110, 1'b0);
        cyc("ori_fetch",  e_fhit(3'b000),   1, 0);
        cyc("ori_dec",    e_dec(3'b000, 0), 1, 0);
        cyc("ori_execi",  e_exi(3'b011),    1, 0);
        cyc("ori_aluwb",  e_awb(3'b000),    1, 0);
        set_instr(7'b0110011, 3'b111, 1'b0);
        cyc("and_fetch",  e_fhit(3'b000),   1, 0);
        cyc("and_dec",    e_dec(3'b000, 0), 1, 0);
        cyc("and_execr",  e_exr(3'b010),    1, 0);
        cyc("and_aluwb",  e_awb(3'b000),    1, 0);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",  e_fhit(3'b011),   1, 0);
        cyc("jal_dec",    e_dec(3'b011, 0), 1, 0);
        cyc("jal_jal",    ev(0,0,0,1,0,0, 2'b00,2'b01,2'b10, 3'b000, 3'b011, 0,0), 1, 0);
        cyc("jal_aluwb",  e_awb(3'b011),    1, 0);

        // Unsupported opcode
        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc("ill_fetch",  e_fhit(3'b000),   1, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc("ill_dec",    e_dec(3'b000, 0), 1, 0);
        for (int i = 0; i < 3; i++)
            cyc("ill_halt", ev(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 3'b000, 0,1), 1, 0);
        rst = 1'b1;
        cyc("ill_rst",    e_fstall(3'b000), 0, 0);
        rst = 1'b0;
`else
        cyc("ill_dec",    e_dec(3'b000, 1), 1, 0);
        cyc("ill_refetch", e_fstall(3'b000), 0, 0);
`endif

        // Asynchronous reset mid-MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("rlw_fetch",  e_fhit(3'b000),   1, 0);
        cyc("rlw_dec",    e_dec(3'b000, 0), 1, 0);
        cyc("rlw_memadr", e_madr(3'b000),   1, 0);
        cyc("rlw_mrstall", e_mrd(3'b000),   0, 0);
        rst = 1'b1;
        cyc("async_rst",  e_fstall(3'b000), 0, 0);
        rst = 1'b0;
        cyc("post_rst",   e_fstall(3'b000), 0, 0);
        cyc("post_fetch", e_fhit(3'b000),   1, 0);
        cyc("post_dec",   e_dec(3'b000, 0), 1, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
